// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer: op codes, FSM states and flag bit positions.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_AND   = 3'd2,
        OP_OR    = 3'd3,
        OP_XOR   = 3'd4,
        OP_SHL   = 3'd5,
        OP_SHR   = 3'd6,
        OP_PASSB = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Purely combinational N-bit ALU producing a result and the {N, Z, C, V} flag word.
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);

    logic [N:0]   sum;
    logic [N:0]   diff;
    logic [N-1:0] res;
    logic         carry;
    logic         ovf;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // For SUB the borrow bit is the inverse of carry: no borrow means a >= b unsigned.
    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (alu_op_t'(op))
            OP_ADD: begin
                res   = sum[N-1:0];
                carry = sum[N];
                ovf   = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_SUB: begin
                res   = diff[N-1:0];
                carry = ~diff[N];
                ovf   = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
            end
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_SHL: begin
                res   = {a[N-2:0], 1'b0};
                carry = a[N-1];
            end
            OP_SHR: begin
                res   = {1'b0, a[N-1:1]};
                carry = a[0];
            end
            OP_PASSB: res = b;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = res[N-1];
        flags[FLAG_Z] = (res == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end

    assign result = res;

endmodule

// File: rtl/alu_sequencer.sv
// Three-state controller running one ALU operation per accepted start, with registered result/flags.
// Optional macro ALU_SEQ_ACCUM_EN lets use_acc take operand A from the previous result.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         use_acc,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [3:0]   flags
);

    seq_state_t   state;
    logic [N-1:0] opnd_a;
    logic [N-1:0] opnd_b;
    logic [2:0]   opnd_op;
    logic [N-1:0] next_a;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;

`ifdef ALU_SEQ_ACCUM_EN
    assign next_a = use_acc ? result : a;
`else
    logic use_acc_unused;
    assign use_acc_unused = use_acc;
    assign next_a         = a;
`endif

    alu_core #(.N(N)) u_core (
        .a      (opnd_a),
        .b      (opnd_b),
        .op     (opnd_op),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // ready/busy/done are registered alongside the state so they always mirror it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            flags   <= '0;
            opnd_a  <= '0;
            opnd_b  <= '0;
            opnd_op <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        opnd_a  <= next_a;
                        opnd_b  <= b;
                        opnd_op <= op;
                        state   <= ST_EXEC;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    result <= alu_result;
                    flags  <= alu_flags;
                    state  <= ST_DONE;
                    done   <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed cases plus random operations against an arithmetic model.
module tb_alu_sequencer;

    localparam int N = 4;
`ifdef ALU_SEQ_ACCUM_EN
    localparam bit ACCUM = 1'b1;
`else
    localparam bit ACCUM = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         use_acc;
    logic         ready;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic [3:0]   flags;

    int         vectors     = 0;
    int         miscompares = 0;
    int         model_result = 0;
    logic [3:0] model_flags  = 4'b0000;

    always #5 clk = ~clk;

    alu_sequencer #(.N(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .use_acc (use_acc),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .flags   (flags)
    );

    // Reference behaviour from plain integer arithmetic on unsigned and signed interpretations.
    function automatic void refModel(input int o, input int av, input int bv,
                                     output int r, output logic [3:0] f);
        int   m;
        int   sa;
        int   sb;
        int   full;
        int   sr;
        logic c;
        logic v;
        m    = 1 << N;
        sa   = (av >= m / 2) ? av - m : av;
        sb   = (bv >= m / 2) ? bv - m : bv;
        c    = 1'b0;
        v    = 1'b0;
        full = 0;
        sr   = 0;
        case (o)
            0: begin full = av + bv; c = (full >= m); sr = sa + sb; v = (sr > m / 2 - 1) || (sr < -(m / 2)); end
            1: begin full = av - bv; c = (av >= bv); sr = sa - sb; v = (sr > m / 2 - 1) || (sr < -(m / 2)); end
            2: full = av & bv;
            3: full = av | bv;
            4: full = av ^ bv;
            5: begin full = av * 2; c = (av >= m / 2); end
            6: begin full = av / 2; c = (av % 2) == 1; end
            default: full = bv;
        endcase
        r = ((full % m) + m) % m;
        f = {(r >= m / 2), (r == 0), c, v};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge in IDLE after the operation completes.
    task automatic applyStimulus(input int o, input int av, input int bv, input logic acc, input bit hold);
        int         opa;
        int         r;
        logic [3:0] f;
        opa = (ACCUM && acc) ? model_result : av;
        refModel(o, opa, bv, r, f);
        op      = 3'(o);
        a       = N'(av);
        b       = N'(bv);
        use_acc = acc;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = hold ? 1'b1 : 1'($urandom_range(0, 1));
        a       = N'($urandom);
        b       = N'($urandom);
        op      = 3'($urandom);
        use_acc = 1'($urandom);
        @(negedge clk);
        checkOutput("exec_done", 16'(done), 16'd0);
        checkOutput("exec_busy", 16'(busy), 16'd1);
        checkOutput("exec_ready", 16'(ready), 16'd0);
        @(negedge clk);
        checkOutput("done_pulse", 16'(done), 16'd1);
        checkOutput("done_result", 16'(result), 16'(r));
        checkOutput("done_flags", 16'(flags), 16'(f));
        model_result = r;
        model_flags  = f;
        @(negedge clk);
        checkOutput("idle_done", 16'(done), 16'd0);
        checkOutput("idle_ready", 16'(ready), 16'd1);
        checkOutput("idle_busy", 16'(busy), 16'd0);
        checkOutput("idle_result_hold", 16'(result), 16'(model_result));
        if (!hold) start = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 3'd0;
        a       = '0;
        b       = '0;
        use_acc = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", 16'(ready), 16'd1);
        checkOutput("rst_busy", 16'(busy), 16'd0);
        checkOutput("rst_done", 16'(done), 16'd0);
        checkOutput("rst_result", 16'(result), 16'd0);
        checkOutput("rst_flags", 16'(flags), 16'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed arithmetic cases");
        applyStimulus(0, 7, 9, 1'b0, 1'b0);
        checkOutput("add79_result", 16'(result), 16'h0);
        checkOutput("add79_flags", 16'(flags), 16'b0110);
        applyStimulus(1, 3, 5, 1'b0, 1'b0);
        checkOutput("sub35_result", 16'(result), 16'hE);
        checkOutput("sub35_flags", 16'(flags), 16'b1000);
        applyStimulus(0, 7, 1, 1'b0, 1'b0);
        checkOutput("add71_result", 16'(result), 16'h8);
        checkOutput("add71_flags", 16'(flags), 16'b1001);
        applyStimulus(5, 9, 6, 1'b0, 1'b0);
        checkOutput("shl9_result", 16'(result), 16'h2);
        checkOutput("shl9_flags", 16'(flags), 16'b0010);
        applyStimulus(6, 1, 12, 1'b0, 1'b0);
        checkOutput("shr1_result", 16'(result), 16'h0);
        checkOutput("shr1_flags", 16'(flags), 16'b0110);

        repeat (3) begin
            @(negedge clk);
            checkOutput("idle_stay_ready", 16'(ready), 16'd1);
            checkOutput("idle_stay_done", 16'(done), 16'd0);
        end

        $display("[TB] start held high");
        applyStimulus(7, 3, 5, 1'b0, 1'b1);
        applyStimulus(4, 12, 10, 1'b0, 1'b1);
        applyStimulus(2, 15, 9, 1'b0, 1'b1);
        start = 1'b0;

        $display("[TB] reset during EXEC");
        applyStimulus(3, 4, 2, 1'b0, 1'b0);
        op = 3'd0; a = 4'd7; b = 4'd9; use_acc = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_ready", 16'(ready), 16'd1);
        checkOutput("arst_busy", 16'(busy), 16'd0);
        checkOutput("arst_done", 16'(done), 16'd0);
        checkOutput("arst_result", 16'(result), 16'd0);
        checkOutput("arst_flags", 16'(flags), 16'd0);
        model_result = 0;
        model_flags  = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("arst_no_done", 16'(done), 16'd0);
            checkOutput("arst_result_hold", 16'(result), 16'd0);
        end

        $display("[TB] accumulate chain");
        applyStimulus(0, 5, 2, 1'b0, 1'b0);
        applyStimulus(0, 0, 3, 1'b1, 1'b0);
        checkOutput("acc_result", 16'(result), ACCUM ? 16'd10 : 16'd3);

        $display("[TB] random operations");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)), 1'($urandom), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
